csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file with trap sequencing, replacing the fixed 64-bit four-register CSR block in the execute stage. It adds the full CSRRW/RS/RC plus immediate variants, mie/mip/mscratch, and free-running mcycle/minstret counters. It also adds hardware trap entry/exit for ecall, mret and a machine timer interrupt, with direct or vectored mtvec. It presents a registered rd writeback and a combinational redirect to the fetch stage.

Parameters:
XLEN, 64, data width of every CSR and datapath port (32 or 64)
MSTATUS_RST, 64'ha00001800, mstatus reset value (truncated to XLEN)
MTVEC_RST, 0, mtvec reset value
HAS_COUNTERS, 1, 1 = implement mcycle/minstret; 0 = both read 0, writes ignored

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  instruction valid at this stage this cycle
csrr  in  1  instruction is a CSR op
ecall  in  1  instruction is ecall
mret  in  1  instruction is mret
retire  in  1  instruction retires (minstret increment)
func3  in  3  CSR op encoding
csr_a  in  12  CSR address
rs1_idx  in  5  rs1 field (zimm for immediate ops)
rs1_val  in  XLEN  forwarded rs1 value
pc  in  XLEN  pc of current instruction
rd_a  in  5  destination index
rd_w  in  1  destination write request
timer_irq  in  1  level machine timer interrupt
rd_o  out  XLEN  registered CSR read data
rd_w_o  out  1  registered rd write enable
rd_a_o  out  5  registered rd index
illegal_o  out  1  registered pulse: unknown CSR address
jup  out  1  redirect, combinational
jup_addr  out  XLEN  redirect target, combinational

Behaviour:
- Reset is clk/rst_n, synchronous, active-low. mstatus=MSTATUS_RST, mtvec=MTVEC_RST; mepc, mcause, mie, mscratch, mcycle and minstret all 0. rd_w_o=0, rd_a_o=0, rd_o=0, illegal_o=0.
- Addresses: 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 344 mip (read-only, bit7=timer_irq), B00 mcycle, B02 minstret. Any other address is illegal.
- Source operand: func3[2]=1 gives src = zero-extended rs1_idx; otherwise src = rs1_val.
- func3[1:0]: 01 write new=src; 10 set new=old|src; 11 clear new=old&~src. For set/clear, src==0 suppresses the write (read still occurs).
- mepc write forces bits[1:0]=0.
- Read value is the pre-write old value. It reaches rd_o one cycle after en. rd_w_o=rd_w, rd_a_o=rd_a.
- Illegal CSR: no write, rd_w_o=0, illegal_o=1 for one cycle.
- When en=0: rd_w_o=0, illegal_o=0, and rd_o/rd_a_o hold.
- Interrupt take: en & mstatus.MIE(3) & mie.MTIE(7) & timer_irq. This has highest priority; the current instruction is not executed (no CSR write, rd_w_o=0, no minstret increment).
  - mcause = {1, 7}; mepc = pc.
  - jup=1; jup_addr = mtvec[1:0]==01 ? base+28 : base, where base = {mtvec[XLEN-1:2],00}.
- ecall (no interrupt): mcause=11, mepc=pc, jup=1, jup_addr=base (never vectored).
- Trap entry: MPIE(7)<=MIE, MIE<=0, MPP(12:11)<=11.
- mret (no interrupt/ecall): MIE<=MPIE, MPIE<=1, MPP<=11, jup=1, jup_addr=mepc.
- Priority: interrupt > ecall > mret > CSR op. jup=0 whenever en=0.
- Counters (HAS_COUNTERS=1): mcycle increments every cycle out of reset. minstret increments when en & retire and no interrupt is taken. Both wrap at 2^XLEN−1 → 0. A CSR write to a counter in the same cycle overrides that cycle's increment.
- Same-cycle CSR write to mstatus/mepc/mtvec plus mret: impossible by decode. If both are asserted, mret wins and the CSR write is dropped.
- Reset asserted mid-trap: all state returns to reset values next edge, and the pending redirect is dropped (jup is gated by rst_n).

Decomposition:
- Shared package csr_pkg holds:
  - CSR address localparams (CSR_MSTATUS … CSR_MINSTRET);
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - cause codes (CAUSE_ECALL_M=11, CAUSE_MTI=7);
  - func3 op encodings.
- One sub-module, csr_rmw, is natural: combinational src select + write/set/clear + write-suppress flag. It is reused later by an S-mode extension.

Test Plan:
- Reset then csrrw 305 with rs1_val=0x80000100 → rd_o=0 next cycle; read back 305 returns 0x80000100.
- csrrs 300, rs1_val=0x8 → MIE set; csrrc 300 with rs1_idx=0 (zero src) → no write, rd_o=0xa00001808.
- ecall at pc=0x80000040, mtvec=0x80000100 → same cycle jup=1, jup_addr=0x80000100. Next cycle mcause=11, mepc=0x80000040, MIE=0, MPIE=1; then mret → jup_addr=0x80000040, MIE=1.
- mtvec=0x80000101, MIE=1, mie=0x80, timer_irq=1 with csrrw pending → jup_addr=0x8000011c, mcause=0x8000000000000007, no CSR write, rd_w_o=0.
- csrrw to 7C0 → illegal_o=1 for one cycle, rd_w_o=0; no CSR changes.
- Write mcycle=0xFFFFFFFFFFFFFFFE → reads 0xFFFFFFFFFFFFFFFF then 0 after wrap. Read B02 after 3 retired instructions → 3.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus/mie/mip bit positions,
// trap cause codes and the CSR read-modify-write op encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MIE_MTIE       = 7;
    localparam int MIP_MTIP       = 7;

    localparam logic [1:0] PRIV_M              = 2'b11;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    localparam logic [4:0] CAUSE_ECALL_M = 5'd11;
    localparam logic [4:0] CAUSE_MTI     = 5'd7;

    // func3[1:0]; func3[2] selects the zero-extended immediate source
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic csr_addr_valid(input logic [11:0] addr);
        logic ok;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/csr_rmw.sv
// Combinational CSR read-modify-write: source select, write/set/clear and the
// write-suppress flag for set/clear with a zero source.
module csr_rmw
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      func3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] old_val,
    output logic [XLEN-1:0] new_val,
    output logic            we
);

    logic [XLEN-1:0] src_s;

    // Source select followed by the op-specific update
    always_comb begin
        src_s   = func3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
        new_val = old_val;
        we      = 1'b0;
        case (csr_op_e'(func3[1:0]))
            CSR_OP_WRITE: begin
                new_val = src_s;
                we      = 1'b1;
            end
            CSR_OP_SET: begin
                new_val = old_val | src_s;
                we      = |src_s;
            end
            CSR_OP_CLEAR: begin
                new_val = old_val & ~src_s;
                we      = |src_s;
            end
            default: begin
                new_val = old_val;
                we      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ecall/mret/timer-interrupt trap sequencing,
// registered rd writeback and a combinational fetch redirect.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          XLEN         = 64,
    parameter logic [63:0] MSTATUS_RST  = 64'ha00001800,
    parameter logic [63:0] MTVEC_RST    = 64'h0,
    parameter int          HAS_COUNTERS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            csrr,
    input  logic            ecall,
    input  logic            mret,
    input  logic            retire,
    input  logic [2:0]      func3,
    input  logic [11:0]     csr_a,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_a,
    input  logic            rd_w,
    input  logic            timer_irq,
    output logic [XLEN-1:0] rd_o,
    output logic            rd_w_o,
    output logic [4:0]      rd_a_o,
    output logic            illegal_o,
    output logic            jup,
    output logic [XLEN-1:0] jup_addr
);

    localparam logic [XLEN-1:0] XLEN_ONE = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic            CNT_EN   = (HAS_COUNTERS != 0);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            rd_w_q, rd_w_d;
    logic [4:0]      rd_a_q, rd_a_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] old_s, mip_s, rmw_new_s, trap_base_s;
    logic            rmw_we_s, addr_ok_s;
    logic            irq_take_s, ecall_take_s, mret_take_s, exec_s, illegal_s, csr_wr_s;

    csr_rmw #(.XLEN(XLEN)) u_rmw (
        .func3   (func3),
        .rs1_idx (rs1_idx),
        .rs1_val (rs1_val),
        .old_val (old_s),
        .new_val (rmw_new_s),
        .we      (rmw_we_s)
    );

    // CSR read mux; the value returned is always the pre-write state
    always_comb begin
        mip_s           = {XLEN{1'b0}};
        mip_s[MIP_MTIP] = timer_irq;
        addr_ok_s       = csr_addr_valid(csr_a);
        case (csr_a)
            CSR_MSTATUS:  old_s = mstatus_q;
            CSR_MIE:      old_s = mie_q;
            CSR_MTVEC:    old_s = mtvec_q;
            CSR_MSCRATCH: old_s = mscratch_q;
            CSR_MEPC:     old_s = mepc_q;
            CSR_MCAUSE:   old_s = mcause_q;
            CSR_MIP:      old_s = mip_s;
            CSR_MCYCLE:   old_s = mcycle_q;
            CSR_MINSTRET: old_s = minstret_q;
            default:      old_s = {XLEN{1'b0}};
        endcase
    end

    // Priority decode: interrupt > ecall > mret > CSR op
    always_comb begin
        irq_take_s   = en & mstatus_q[MSTATUS_MIE] & mie_q[MIE_MTIE] & timer_irq;
        ecall_take_s = en & ecall & ~irq_take_s;
        mret_take_s  = en & mret & ~ecall & ~irq_take_s;
        exec_s       = en & ~irq_take_s;
        illegal_s    = exec_s & csrr & ~addr_ok_s;
        csr_wr_s     = exec_s & csrr & addr_ok_s & ~ecall & ~mret & rmw_we_s;
    end

    // Redirect to fetch; dropped while reset is asserted
    always_comb begin
        trap_base_s = {mtvec_q[XLEN-1:2], 2'b00};
        jup         = rst_n & (irq_take_s | ecall_take_s | mret_take_s);
        if (mret_take_s) begin
            jup_addr = mepc_q;
        end else if (irq_take_s && (mtvec_q[1:0] == MTVEC_MODE_VECTORED)) begin
            jup_addr = trap_base_s + {{(XLEN-7){1'b0}}, CAUSE_MTI, 2'b00};
        end else begin
            jup_addr = trap_base_s;
        end
    end

    // CSR next-state: counters, then CSR write, then trap entry/exit
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = CNT_EN ? (mcycle_q + XLEN_ONE) : mcycle_q;
        if (CNT_EN && exec_s && retire) begin
            minstret_d = minstret_q + XLEN_ONE;
        end else begin
            minstret_d = minstret_q;
        end

        if (csr_wr_s) begin
            case (csr_a)
                CSR_MSTATUS:  mstatus_d  = rmw_new_s;
                CSR_MIE:      mie_d      = rmw_new_s;
                CSR_MTVEC:    mtvec_d    = rmw_new_s;
                CSR_MSCRATCH: mscratch_d = rmw_new_s;
                CSR_MEPC:     mepc_d     = {rmw_new_s[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = rmw_new_s;
                CSR_MCYCLE:   mcycle_d   = CNT_EN ? rmw_new_s : mcycle_q;
                CSR_MINSTRET: minstret_d = CNT_EN ? rmw_new_s : minstret_q;
                default:      mstatus_d  = mstatus_q;
            endcase
        end else begin
            mstatus_d = mstatus_q;
        end

        if (irq_take_s || ecall_take_s) begin
            mepc_d                                  = pc;
            mcause_d                                = irq_take_s
                ? {1'b1, {(XLEN-6){1'b0}}, CAUSE_MTI}
                : {{(XLEN-5){1'b0}}, CAUSE_ECALL_M};
            mstatus_d[MSTATUS_MPIE]                 = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                  = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        end else if (mret_take_s) begin
            mstatus_d[MSTATUS_MIE]                  = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                 = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        end else begin
            mepc_d = mepc_d;
        end
    end

    // Writeback next-state: rd_o/rd_a_o hold when nothing executes
    always_comb begin
        if (exec_s) begin
            rd_d      = old_s;
            rd_a_d    = rd_a;
            rd_w_d    = rd_w & ~illegal_s;
            illegal_d = illegal_s;
        end else begin
            rd_d      = rd_q;
            rd_a_d    = rd_a_q;
            rd_w_d    = 1'b0;
            illegal_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= MSTATUS_RST[XLEN-1:0];
            mie_q      <= {XLEN{1'b0}};
            mtvec_q    <= MTVEC_RST[XLEN-1:0];
            mscratch_q <= {XLEN{1'b0}};
            mepc_q     <= {XLEN{1'b0}};
            mcause_q   <= {XLEN{1'b0}};
            mcycle_q   <= {XLEN{1'b0}};
            minstret_q <= {XLEN{1'b0}};
            rd_q       <= {XLEN{1'b0}};
            rd_w_q     <= 1'b0;
            rd_a_q     <= 5'd0;
            illegal_q  <= 1'b0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            rd_q       <= rd_d;
            rd_w_q     <= rd_w_d;
            rd_a_q     <= rd_a_d;
            illegal_q  <= illegal_d;
        end
    end

    assign rd_o      = rd_q;
    assign rd_w_o    = rd_w_q;
    assign rd_a_o    = rd_a_q;
    assign illegal_o = illegal_q;

endmodule
